// File: rtl/arc4_pkg.sv
// Shared types and helpers for the ARC4 key-scheduling engine: FSM state
// encoding, default geometry and MSB-first key byte selection.
package arc4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RD_I,
    CAP_I,
    RD_J,
    CAP_J,
    WR_I,
    WR_J
  } ksa_state_t;

  localparam int ARC4_DEPTH_LOG2    = 8;
  localparam int ARC4_KEY_BYTES     = 3;
  localparam int ARC4_KEY_BYTES_MAX = 32;
  localparam int ARC4_KEY_W_MAX     = ARC4_KEY_BYTES_MAX * 8;

  // Key must be left-aligned in the maximum-width vector so byte 0 sits at the top.
  function automatic logic [7:0] key_byte(input logic [ARC4_KEY_W_MAX-1:0] key,
                                          input int unsigned idx);
    return 8'(key >> (ARC4_KEY_W_MAX - 8 - 8 * idx));
  endfunction

endpackage

// File: rtl/arc4_ksa_ctrl.sv
// Sequencing FSM and i/j index counters for the ARC4 key-scheduling engine.
// j is loaded from the datapath's adder in CAP_I; everything else is local.
module arc4_ksa_ctrl
  import arc4_pkg::*;
#(
  parameter int DEPTH_LOG2 = ARC4_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DEPTH_LOG2-1:0] j_nxt,
  output ksa_state_t            state,
  output logic                  rdy,
  output logic [DEPTH_LOG2-1:0] i,
  output logic [DEPTH_LOG2-1:0] j
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdy   <= 1'b1;
      i     <= '0;
      j     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state <= INIT;
            rdy   <= 1'b0;
            i     <= '0;
            j     <= '0;
          end
        end
        // i wraps to zero on its own after the last identity write
        INIT: begin
          i <= i + 1'b1;
          if (&i) begin
            state <= RD_I;
            j     <= '0;
          end
        end
        RD_I:  state <= CAP_I;
        CAP_I: begin
          j     <= j_nxt;
          state <= RD_J;
        end
        RD_J:  state <= CAP_J;
        CAP_J: state <= WR_I;
        WR_I:  state <= WR_J;
        WR_J: begin
          i <= i + 1'b1;
          if (&i) begin
            state <= IDLE;
            rdy   <= 1'b1;
          end else begin
            state <= RD_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/arc4_ksa_engine.sv
// ARC4 S-array initialiser plus key-scheduling loop over an external 1-cycle-latency RAM.
// Optional build macro ARC4_KSA_CHECKSUM_EN adds a running XOR of written words on chk.
module arc4_ksa_engine
  import arc4_pkg::*;
#(
  parameter int DEPTH_LOG2 = ARC4_DEPTH_LOG2,
  parameter int KEY_BYTES  = ARC4_KEY_BYTES,
  parameter int DATA_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [KEY_BYTES*8-1:0] key,
  output logic [DEPTH_LOG2-1:0]  addr,
  input  logic [DATA_W-1:0]      rddata,
  output logic [DATA_W-1:0]      wrdata,
  output logic                   wren
`ifdef ARC4_KSA_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]      chk
`endif
);

  localparam int KEY_W = KEY_BYTES * 8;

  ksa_state_t               state;
  logic                     accept;
  logic [DEPTH_LOG2-1:0]    i;
  logic [DEPTH_LOG2-1:0]    j;
  logic [DEPTH_LOG2-1:0]    j_nxt;
  logic [KEY_W-1:0]         key_q;
  logic [ARC4_KEY_W_MAX-1:0] key_al;
  logic [7:0]               kb;
  int unsigned              kidx;
  logic [DATA_W-1:0]        si;
  logic [DATA_W-1:0]        sj;

  assign accept = en && rdy;

  arc4_ksa_ctrl #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ctrl (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .j_nxt(j_nxt),
    .state(state),
    .rdy  (rdy),
    .i    (i),
    .j    (j)
  );

  always_ff @(posedge clk) begin
    if (accept) key_q <= key;
    if (state == CAP_I) si <= rddata;
    if (state == CAP_J) sj <= rddata;
  end

  // S[i] arrives on rddata during CAP_I, so the adder uses it directly
  always_comb begin
    key_al = ARC4_KEY_W_MAX'(key_q) << (ARC4_KEY_W_MAX - KEY_W);
    kidx   = 32'(i) % 32'(KEY_BYTES);
    kb     = key_byte(key_al, kidx);
    j_nxt  = j + rddata[DEPTH_LOG2-1:0] + kb[DEPTH_LOG2-1:0];
  end

  always_comb begin
    addr   = '0;
    wrdata = '0;
    wren   = 1'b0;
    case (state)
      INIT: begin
        addr   = i;
        wrdata = DATA_W'(i);
        wren   = 1'b1;
      end
      RD_I, CAP_I: addr = i;
      RD_J, CAP_J: addr = j;
      WR_I: begin
        addr   = i;
        wrdata = sj;
        wren   = 1'b1;
      end
      WR_J: begin
        addr   = j;
        wrdata = si;
        wren   = 1'b1;
      end
      default: addr = '0;
    endcase
  end

`ifdef ARC4_KSA_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || accept) chk <= '0;
    else if (wren)     chk <= chk ^ wrdata;
  end
`endif

endmodule

// File: tb/tb_arc4_ksa_engine.sv
// Directed bench for arc4_ksa_engine: a 256-entry instance keyed with 3 bytes and a
// 4-entry instance keyed with 1 byte, each on its own behavioural 1-cycle-latency RAM.
module tb_arc4_ksa_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        b_en, b_rdy, b_wren;
  logic [23:0] b_key;
  logic [7:0]  b_addr, b_rddata, b_wrdata;
  logic [7:0]  b_chk;

  logic        s_en, s_rdy, s_wren;
  logic [7:0]  s_key;
  logic [1:0]  s_addr;
  logic [7:0]  s_rddata, s_wrdata;
  logic [7:0]  s_chk;

  logic [7:0]  bmem [256];
  logic [7:0]  smem [4];
  logic [7:0]  gold [256];

  logic [7:0]  s_log_xor;
  int          s_log_n;

  int vectors    = 0;
  int miscompares = 0;

  arc4_ksa_engine #(.DEPTH_LOG2(8), .KEY_BYTES(3), .DATA_W(8)) u_big (
    .clk   (clk),
    .rst   (rst),
    .en    (b_en),
    .rdy   (b_rdy),
    .key   (b_key),
    .addr  (b_addr),
    .rddata(b_rddata),
    .wrdata(b_wrdata),
    .wren  (b_wren)
`ifdef ARC4_KSA_CHECKSUM_EN
    ,
    .chk   (b_chk)
`endif
  );

  arc4_ksa_engine #(.DEPTH_LOG2(2), .KEY_BYTES(1), .DATA_W(8)) u_small (
    .clk   (clk),
    .rst   (rst),
    .en    (s_en),
    .rdy   (s_rdy),
    .key   (s_key),
    .addr  (s_addr),
    .rddata(s_rddata),
    .wrdata(s_wrdata),
    .wren  (s_wren)
`ifdef ARC4_KSA_CHECKSUM_EN
    ,
    .chk   (s_chk)
`endif
  );

`ifndef ARC4_KSA_CHECKSUM_EN
  assign b_chk = 8'h00;
  assign s_chk = 8'h00;
`endif

  always @(posedge clk) begin
    if (b_wren) bmem[b_addr] <= b_wrdata;
    b_rddata <= bmem[b_addr];
    if (s_wren) smem[s_addr] <= s_wrdata;
    s_rddata <= smem[s_addr];
  end

  // A write visible at a falling edge is committed at the following rising edge
  always @(negedge clk) begin
    if (s_wren) begin
      s_log_xor = s_log_xor ^ s_wrdata;
      s_log_n   = s_log_n + 1;
    end
  end

  task automatic compute_gold(input logic [23:0] k);
    int jj;
    logic [7:0] kb, t;
    for (int ii = 0; ii < 256; ii++) gold[ii] = 8'(ii);
    jj = 0;
    for (int ii = 0; ii < 256; ii++) begin
      kb = 8'(k >> (16 - 8 * (ii % 3)));
      jj = (jj + int'(gold[ii]) + int'(kb)) % 256;
      t = gold[ii];
      gold[ii] = gold[jj];
      gold[jj] = t;
    end
  endtask

  task automatic start_big(input logic [23:0] k);
    @(negedge clk);
    b_key = k;
    b_en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_en  = 1'b0;
    b_key = ~k;
  endtask

  task automatic start_small(input logic [7:0] k);
    @(negedge clk);
    s_key = k;
    s_en  = 1'b1;
    @(posedge clk);
    s_log_xor = 8'h00;
    s_log_n   = 0;
    @(negedge clk);
    s_en  = 1'b0;
    s_key = ~k;
  endtask

  task automatic test_reset();
    int wcount;
    rst = 1'b1;
    b_en = 1'b0; s_en = 1'b0;
    b_key = 24'h0; s_key = 8'h0;
    s_log_xor = 8'h00; s_log_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (b_rdy !== 1'b1 || s_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_rdy: got big=%b small=%b expected 1", b_rdy, s_rdy);
    end
    vectors++;
    if (b_wren !== 1'b0 || s_wren !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wren: got big=%b small=%b expected 0", b_wren, s_wren);
    end
    vectors++;
    if (b_addr !== 8'h00 || s_addr !== 2'b00 || b_wrdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_addr: got addr=%0h/%0h wrdata=%0h expected 0", b_addr, s_addr, b_wrdata);
    end
`ifdef ARC4_KSA_CHECKSUM_EN
    vectors++;
    if (b_chk !== 8'h00 || s_chk !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_chk: got %0h/%0h expected 0", b_chk, s_chk);
    end
`endif
    rst = 1'b0;
    wcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (b_wren || s_wren || !b_rdy || !s_rdy) wcount++;
    end
    vectors++;
    if (wcount !== 0) begin
      miscompares++;
      $display("FAIL idle_no_activity: got %0d active cycles expected 0", wcount);
    end
  endtask

  task automatic test_init_big();
    int bad, n;
    start_big(24'h0A0B0C);
    bad = 0;
    for (int c = 0; c < 256; c++) begin
      if (!(b_wren === 1'b1 && b_addr === 8'(c) && b_wrdata === 8'(c))) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL init_writes: got %0d bad cycles expected 0", bad);
    end
    vectors++;
    if (b_wren !== 1'b0 || b_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL first_rd_i: got wren=%b addr=%0h expected 0/0", b_wren, b_addr);
    end
    bad = 0;
    for (int a = 0; a < 256; a++) if (bmem[a] !== 8'(a)) bad++;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL init_identity: got %0d wrong entries expected 0", bad);
    end
    n = 256;
    while (!b_rdy && n < 3000) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n !== 1792) begin
      miscompares++;
      $display("FAIL big_latency: got %0d cycles expected 1792", n);
    end
    compute_gold(24'h0A0B0C);
    bad = 0;
    for (int a = 0; a < 256; a++) if (bmem[a] !== gold[a]) bad++;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL big_ksa_0a0b0c: got %0d wrong entries expected 0", bad);
    end
  endtask

  task automatic test_ksa_key01();
    int n;
    start_small(8'h01);
`ifdef ARC4_KSA_CHECKSUM_EN
    vectors++;
    if (s_chk !== 8'h00) begin
      miscompares++;
      $display("FAIL chk_after_accept: got %0h expected 0", s_chk);
    end
`endif
    n = 0;
    while (!s_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n !== 28) begin
      miscompares++;
      $display("FAIL small_latency_k01: got %0d cycles expected 28", n);
    end
    vectors++;
    if ({smem[0], smem[1], smem[2], smem[3]} !== {8'd0, 8'd2, 8'd3, 8'd1}) begin
      miscompares++;
      $display("FAIL ksa_k01: got %0h %0h %0h %0h expected 0 2 3 1", smem[0], smem[1], smem[2], smem[3]);
    end
    vectors++;
    if (s_log_n !== 12) begin
      miscompares++;
      $display("FAIL write_count_k01: got %0d expected 12", s_log_n);
    end
`ifdef ARC4_KSA_CHECKSUM_EN
    vectors++;
    if (s_chk !== 8'h01 || s_chk !== s_log_xor) begin
      miscompares++;
      $display("FAIL chk_k01: got %0h expected 01 (logged %0h)", s_chk, s_log_xor);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (s_chk !== 8'h01) begin
      miscompares++;
      $display("FAIL chk_hold: got %0h expected 01", s_chk);
    end
`endif
  endtask

  task automatic test_ksa_key00();
    int n;
    start_small(8'h00);
    repeat (22) @(negedge clk);
    vectors++;
    if ({smem[0], smem[1], smem[2], smem[3]} !== {8'd0, 8'd1, 8'd3, 8'd2}) begin
      miscompares++;
      $display("FAIL ksa_k00_after_i2: got %0h %0h %0h %0h expected 0 1 3 2", smem[0], smem[1], smem[2], smem[3]);
    end
    n = 22;
    while (!s_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n !== 28) begin
      miscompares++;
      $display("FAIL small_latency_k00: got %0d cycles expected 28", n);
    end
    vectors++;
    if ({smem[0], smem[1], smem[2], smem[3]} !== {8'd0, 8'd2, 8'd3, 8'd1}) begin
      miscompares++;
      $display("FAIL ksa_k00_final: got %0h %0h %0h %0h expected 0 2 3 1", smem[0], smem[1], smem[2], smem[3]);
    end
  endtask

  task automatic test_mid_reset();
    int n, bad;
    start_big(24'h00033C);
    repeat (399) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (b_rdy !== 1'b1 || b_wren !== 1'b0 || b_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset_idle: got rdy=%b wren=%b addr=%0h expected 1/0/0", b_rdy, b_wren, b_addr);
    end
    start_big(24'h00033C);
    n = 0;
    while (!b_rdy && n < 3000) begin
      b_en  = (n == 10 || n == 500 || n == 1500);
      b_key = 24'hFFFFFF;
      n++;
      @(negedge clk);
    end
    b_en = 1'b0;
    vectors++;
    if (n !== 1792) begin
      miscompares++;
      $display("FAIL restart_latency: got %0d cycles expected 1792", n);
    end
    compute_gold(24'h00033C);
    bad = 0;
    for (int a = 0; a < 256; a++) if (bmem[a] !== gold[a]) bad++;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL big_ksa_00033c: got %0d wrong entries expected 0", bad);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (b_rdy !== 1'b1 || b_wren !== 1'b0) begin
      miscompares++;
      $display("FAIL no_queued_start: got rdy=%b wren=%b expected 1/0", b_rdy, b_wren);
    end
  endtask

  initial begin
    test_reset();
    test_init_big();
    test_ksa_key01();
    test_ksa_key00();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
